spi_cmd_master: RTL and testbench

- Host-side SPI master that drives the command/payload link into the bridge's SPI slave.
- Per transaction:
  - spi_csn_o goes low.
  - One command byte is sent first.
  - len_i payload bytes follow, pulled from a valid/ready byte stream.
  - spi_csn_o goes high; the slave acts on this rising edge.
- Used in the companion host/test FPGA and as the bench driver for the bridge.
- Mode 0 (CPOL=0, CPHA=0), MSB first.

---
 rtl/spi_link_pkg.sv | 17 +
 rtl/spi_clk_gen.sv | 35 +++
 rtl/spi_cmd_master.sv | 127 ++++++++++++
 tb/tb_spi_cmd_master.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_link_pkg.sv
// rtl/spi_link_pkg.sv - shared SPI link state encoding and command opcodes
package spi_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LOAD  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    localparam logic [7:0] CMD_LCD_INIT     = 8'h89;
    localparam logic [7:0] CMD_LCD_TP_FIRST = 8'hCF;
    localparam logic [7:0] CMD_LCD_TP_NEXT  = 8'hD9;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK half-period counter with rise/fall strobes
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_r;
    logic          phase_r;
    logic          tick;

    assign tick = en && (cnt_r == CW'(CLK_DIV - 1));
    assign rise = tick && !phase_r;
    assign fall = tick && phase_r;

    // Disabling restarts a fresh low phase so every byte begins identically.
    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (tick) begin
            cnt_r   <= '0;
            phase_r <= !phase_r;
        end else begin
            cnt_r   <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/spi_cmd_master.sv
// rtl/spi_cmd_master.sv - mode 0 SPI master sending a command byte plus streamed payload
module spi_cmd_master
    import spi_link_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 8,
    parameter int LEN_W    = 16
) (
    input  logic             clk_i,
    input  logic             nsys_reset,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [7:0]       cmd_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    input  logic [7:0]       data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             spi_clk_o,
    output logic             spi_mosi_o,
    output logic             spi_csn_o
);

    state_t           state;
    logic [7:0]       shift_r;
    logic [LEN_W-1:0] remain_r;
    logic [2:0]       bit_cnt;
    logic [7:0]       tmr_r;
    logic             shift_en;
    logic             rise;
    logic             fall;

    assign shift_en     = (state == ST_SHIFT);
    assign cmd_ready_o  = (state == ST_IDLE);
    assign busy_o       = (state != ST_IDLE);
    assign data_ready_o = (state == ST_LOAD) && data_valid_i;
    // MOSI is the MSB of a register, so it is glitch-free and holds between bytes.
    assign spi_mosi_o   = shift_r[7];

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk    (clk_i),
        .resetn (nsys_reset),
        .en     (shift_en),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk_i) begin
        if (!nsys_reset) begin
            state     <= ST_IDLE;
            shift_r   <= '0;
            remain_r  <= '0;
            bit_cnt   <= '0;
            tmr_r     <= '0;
            spi_csn_o <= 1'b1;
            spi_clk_o <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        shift_r   <= cmd_i;
                        remain_r  <= len_i;
                        tmr_r     <= '0;
                        spi_csn_o <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_r == 8'(CS_SETUP - 1)) begin
                        tmr_r   <= '0;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end else begin
                        tmr_r <= tmr_r + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (rise) begin
                        spi_clk_o <= 1'b1;
                    end else if (fall) begin
                        spi_clk_o <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            state <= (remain_r != '0) ? ST_LOAD : ST_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift_r <= {shift_r[6:0], 1'b0};
                        end
                    end
                end
                ST_LOAD: begin
                    if (data_valid_i) begin
                        shift_r  <= data_i;
                        remain_r <= remain_r - LEN_W'(1);
                        bit_cnt  <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_HOLD: begin
                    if (tmr_r == 8'(CS_HOLD - 1)) begin
                        tmr_r     <= '0;
                        shift_r   <= '0;
                        spi_csn_o <= 1'b1;
                        done_o    <= 1'b1;
                        state     <= ST_GAP;
                    end else begin
                        tmr_r <= tmr_r + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (tmr_r == 8'(CS_GAP - 1)) begin
                        tmr_r <= '0;
                        state <= ST_IDLE;
                    end else begin
                        tmr_r <= tmr_r + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_master.sv
// tb/tb_spi_cmd_master.sv - randomized timeline-model bench for spi_cmd_master
module tb_spi_cmd_master;
    import spi_link_pkg::*;

    localparam int CLK_DIV = 4, CS_SETUP = 4, CS_HOLD = 4, CS_GAP = 8;

    logic        clk = 1'b0;
    logic        nsys_reset = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [7:0]  cmd_i = '0;
    logic [15:0] len_i = '0;
    logic        data_valid_i = 1'b0;
    logic        data_ready_o;
    logic [7:0]  data_i = '0;
    logic        busy_o, done_o, spi_clk_o, spi_mosi_o, spi_csn_o;

    always #5 clk = ~clk;

    spi_cmd_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
                     .CS_GAP(CS_GAP), .LEN_W(16)) dut (
        .clk_i(clk), .nsys_reset(nsys_reset), .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o), .cmd_i(cmd_i), .len_i(len_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .busy_o(busy_o), .done_o(done_o), .spi_clk_o(spi_clk_o),
        .spi_mosi_o(spi_mosi_o), .spi_csn_o(spi_csn_o)
    );

    // One entry per clock: inputs to drive and the outputs that cycle must show.
    typedef struct {
        bit rst, cv, dv, chk;
        logic [7:0] cmd, d;
        logic [15:0] len;
        bit csn, sclk, mosi, chk_mosi, busy, crdy, drdy, done;
    } ent_t;

    ent_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    function automatic ent_t mk(bit csn, bit sclk, bit mosi, bit busy);
        ent_t e;
        e.rst = 1'b1; e.chk = 1'b1;
        e.cv  = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        e.cmd = 8'($urandom); e.len = 16'($urandom);
        e.dv  = 1'($urandom_range(0, 1)); e.d = 8'($urandom);
        e.csn = csn; e.sclk = sclk; e.mosi = mosi; e.chk_mosi = !csn;
        e.busy = busy; e.crdy = !busy; e.drdy = 1'b0; e.done = 1'b0;
        return e;
    endfunction

    task automatic push_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            for (int k = 0; k < CLK_DIV; k++) q.push_back(mk(1'b0, 1'b0, v[i], 1'b1));
            for (int k = 0; k < CLK_DIV; k++) q.push_back(mk(1'b0, 1'b1, v[i], 1'b1));
        end
    endtask

    task automatic build_txn(input logic [7:0] cmd, input int len, input logic [7:0] pay[$],
                             input int stalls[$], input int idle_n);
        ent_t e;
        logic [7:0] bytes[$];
        logic [7:0] cur;
        bytes.push_back(cmd);
        foreach (pay[i]) bytes.push_back(pay[i]);
        for (int i = 0; i < idle_n - 1; i++) q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
        e = mk(1'b1, 1'b0, 1'b0, 1'b0);
        e.cv = 1'b1; e.cmd = cmd; e.len = 16'(len);
        q.push_back(e);
        for (int i = 0; i < CS_SETUP; i++) q.push_back(mk(1'b0, 1'b0, cmd[7], 1'b1));
        for (int b = 0; b <= len; b++) begin
            cur = bytes[b];
            push_byte(cur);
            if (b < len) begin
                for (int s = 0; s < stalls[b]; s++) begin
                    e = mk(1'b0, 1'b0, cur[0], 1'b1); e.dv = 1'b0;
                    q.push_back(e);
                end
                e = mk(1'b0, 1'b0, cur[0], 1'b1);
                e.dv = 1'b1; e.d = bytes[b+1]; e.drdy = 1'b1;
                q.push_back(e);
            end
        end
        cur = bytes[len];
        for (int i = 0; i < CS_HOLD; i++) q.push_back(mk(1'b0, 1'b0, cur[0], 1'b1));
        e = mk(1'b1, 1'b0, 1'b0, 1'b1); e.done = 1'b1;
        q.push_back(e);
        for (int i = 1; i < CS_GAP; i++) q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic play();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk); #1;
            nsys_reset = e.rst; cmd_valid_i = e.cv; cmd_i = e.cmd; len_i = e.len;
            data_valid_i = e.dv; data_i = e.d;
            @(negedge clk);
            cyc++;
            if (e.chk) begin
                vectors++;
                if (spi_csn_o !== e.csn || spi_clk_o !== e.sclk || busy_o !== e.busy ||
                    cmd_ready_o !== e.crdy || data_ready_o !== e.drdy || done_o !== e.done ||
                    (e.chk_mosi && spi_mosi_o !== e.mosi)) begin
                    miscompares++;
                    $display("FAIL cycle %0d csn,sclk,mosi,busy,crdy,drdy,done got %b%b%b%b%b%b%b want %b%b%b%b%b%b%b",
                             cyc, spi_csn_o, spi_clk_o, spi_mosi_o, busy_o, cmd_ready_o,
                             data_ready_o, done_o, e.csn, e.sclk, e.mosi, e.busy, e.crdy,
                             e.drdy, e.done);
                end
            end
        end
    endtask

    // Independent slave-side monitor: captures bytes on SCLK rises, closes on csn rise.
    logic [7:0] m_sh;
    logic [7:0] m_bytes[$], last_bytes[$];
    int m_bits = 0, m_rises = 0, m_low = 0, m_drdy = 0, m_high = 100, min_high = 1000;
    int last_rises = 0, last_low = 0, last_drdy = 0;
    bit p_csn = 1'b1, p_sclk = 1'b0;

    always @(negedge clk) begin
        if (spi_csn_o === 1'b0) begin
            if (p_csn) begin
                m_bits = 0; m_rises = 0; m_low = 0; m_drdy = 0; m_bytes.delete();
                if (m_high < min_high) min_high = m_high;
            end
            m_low++;
            if (spi_clk_o && !p_sclk) begin
                m_rises++;
                m_sh = {m_sh[6:0], spi_mosi_o};
                m_bits++;
                if (m_bits == 8) begin m_bytes.push_back(m_sh); m_bits = 0; end
            end
        end else begin
            if (!p_csn) begin
                last_low = m_low; last_rises = m_rises; last_drdy = m_drdy;
                last_bytes = m_bytes; m_high = 0;
            end
            m_high++;
        end
        if (data_ready_o === 1'b1) m_drdy++;
        p_csn = spi_csn_o; p_sclk = spi_clk_o;
    end

    task automatic chk_int(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic check_rec(input string nm, input int low, input int rises, input int drdy,
                             input logic [7:0] exp[$]);
        chk_int({nm, " csn_low_cycles"}, last_low, low);
        chk_int({nm, " sclk_rises"}, last_rises, rises);
        chk_int({nm, " data_ready_pulses"}, last_drdy, drdy);
        chk_int({nm, " byte_count"}, last_bytes.size(), exp.size());
        foreach (exp[i])
            if (i < last_bytes.size()) chk_int({nm, " byte"}, int'(last_bytes[i]), int'(exp[i]));
    endtask

    task automatic run_txn(input string nm, input logic [7:0] cmd, input int len,
                           input int stall_idx, input int stall_len, input int idle_n,
                           input int low_lit);
        logic [7:0] pay[$], exp[$];
        int stalls[$];
        int low;
        low = CS_SETUP + 16 * CLK_DIV * (len + 1) + CS_HOLD;
        for (int i = 0; i < len; i++) begin
            pay.push_back(8'($urandom));
            stalls.push_back(i == stall_idx ? stall_len : 0);
            low += stalls[i] + 1;
        end
        if (nm == "cf3" || nm == "cf3stall") begin
            pay[0] = 8'hA5; pay[1] = 8'h5A; pay[2] = 8'hFF;
        end
        exp.push_back(cmd);
        foreach (pay[i]) exp.push_back(pay[i]);
        build_txn(cmd, len, pay, stalls, idle_n);
        play();
        check_rec(nm, (low_lit >= 0) ? low_lit : low, 8 * (len + 1), len, exp);
    endtask

    initial begin
        ent_t e;
        logic [7:0] pay[$];
        int stalls[$];
        int n, ln;
        e = mk(1'b1, 1'b0, 1'b0, 1'b0); e.rst = 1'b0; e.chk = 1'b0;
        q.push_back(e); q.push_back(e);
        for (int i = 0; i < 3; i++) q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
        play();

        run_txn("init", CMD_LCD_INIT, 0, -1, 0, 2, 72);
        run_txn("cf3", CMD_LCD_TP_FIRST, 3, -1, 0, 1, 267);
        run_txn("cf3stall", CMD_LCD_TP_FIRST, 3, 1, 50, 1, 317);
        run_txn("b2b_a", 8'h5C, 1, -1, 0, 1, -1);
        run_txn("b2b_b", 8'hA3, 0, -1, 0, 1, -1);

        // Abort in the middle of payload byte 1 of a len=4 transfer.
        pay.delete(); stalls.delete();
        for (int i = 0; i < 4; i++) begin pay.push_back(8'($urandom)); stalls.push_back(0); end
        build_txn(8'h3C, 4, pay, stalls, 1);
        n = 1 + CS_SETUP + 16 * CLK_DIV + 1 + 30;
        while (q.size() > n) void'(q.pop_back());
        q[q.size() - 1].rst = 1'b0;
        for (int i = 0; i < 10; i++) q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
        play();
        run_txn("after_reset", 8'h96, 2, 0, 3, 1, -1);

        for (int t = 0; t < 12; t++) begin
            ln = $urandom_range(0, 4);
            run_txn("rand", 8'($urandom), ln, $urandom_range(0, 4), $urandom_range(0, 6),
                    $urandom_range(1, 3), -1);
        end

        run_txn("loop_d9", CMD_LCD_TP_NEXT, 240, 7, 5, 2, -1);
        chk_int("loop_d9 first_byte", int'(last_bytes[0]), 'hD9);
        chk_int("loop_d9 captured_241", last_bytes.size(), 241);
        vectors++;
        if (min_high < CS_GAP) begin
            miscompares++;
            $display("FAIL min_csn_high got %0d want >= %0d", min_high, CS_GAP);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
